// File: rtl/mult_tdm_pkg.sv
// Shared types for the time-division multiplier scheduler: FSM state
// encoding, default multiplier latency and the in-flight beat tag.
package mult_tdm_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_t;

    localparam int MULT_LAT_DEF = 3;

    // Tag id is sized for the largest supported requester count; the top
    // narrows it back to its own ID width.
    localparam int TAG_ID_W = 8;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    localparam int TAG_BITS = $bits(tag_t);

endpackage

// File: rtl/mult_tag_pipe.sv
// Shift register of beat tags that runs alongside the shared multiplier so
// each product leaves with the ID of the requester that issued it.
module mult_tag_pipe
    import mult_tdm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [TAG_BITS-1:0] tag_i,
    output logic [TAG_BITS-1:0] tag_o,
    output logic                any_valid_o
);

    tag_t stage_q [DEPTH];
    tag_t stage_d [DEPTH];

    // Next-state: shift every stage one step toward the output.
    always_comb begin
        stage_d[0] = tag_t'(tag_i);
        for (int k = 1; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    // Stage registers; reset drops every beat still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // Any-valid reduction over all stages for the busy indication.
    always_comb begin
        any_valid_o = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            any_valid_o = any_valid_o | stage_q[k].valid;
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mult_tdm_sched.sv
// Round-robin burst scheduler sharing one pipelined signed multiplier
// between NUM_REQ operand streams; products return tagged with their source.
module mult_tdm_sched
    import mult_tdm_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int WIDTH_A   = 8,
    parameter  int WIDTH_B   = 8,
    parameter  int BURST_LEN = 4,
    parameter  int MULT_LAT  = MULT_LAT_DEF,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*WIDTH_A-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH_B-1:0]   req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [WIDTH_A-1:0]           mult_a,
    output logic [WIDTH_B-1:0]           mult_b,
    input  logic [WIDTH_A+WIDTH_B-1:0]   mult_p,
    output logic                         res_valid,
    output logic [ID_W-1:0]              res_id,
    output logic [WIDTH_A+WIDTH_B-1:0]   res_p,
    output logic                         busy
);

    localparam int P_W   = WIDTH_A + WIDTH_B;
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    sched_state_t       state_q, state_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH_A-1:0] mult_a_q, mult_a_d;
    logic [WIDTH_B-1:0] mult_b_q, mult_b_d;
    logic               res_valid_q;
    logic [ID_W-1:0]    res_id_q;
    logic [P_W-1:0]     res_p_q;

    logic [NUM_REQ-1:0] req_ready_s;
    logic [ID_W-1:0]    pick_id_s;
    logic [ID_W-1:0]    scan_idx_s;
    logic [ID_W-1:0]    next_owner_s;
    tag_t               tag_in_s;
    tag_t               tag_out_s;
    logic [TAG_BITS-1:0] tag_out_vec_s;
    logic               tag_any_s;

    // Round-robin pick: scan downward so the last hit is the first index at or after rr_ptr.
    always_comb begin
        pick_id_s  = '0;
        scan_idx_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx_s = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid[scan_idx_s]) begin
                pick_id_s = scan_idx_s;
            end else begin
                pick_id_s = pick_id_s;
            end
        end
    end

    assign next_owner_s = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);

    // FSM next state, ready decode, operand capture and tag push.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        mult_a_d    = mult_a_q;
        mult_b_d    = mult_b_q;
        req_ready_s = '0;
        tag_in_s    = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d = BURST;
                    owner_d = pick_id_s;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                req_ready_s[owner_q] = 1'b1;
                if (req_valid[owner_q]) begin
                    mult_a_d       = req_a[owner_q*WIDTH_A +: WIDTH_A];
                    mult_b_d       = req_b[owner_q*WIDTH_B +: WIDTH_B];
                    cnt_d          = cnt_q + CNT_W'(1);
                    tag_in_s.valid = 1'b1;
                    tag_in_s.id    = TAG_ID_W'(owner_q);
                    if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_owner_s;
                    end else begin
                        state_d = BURST;
                    end
                end else begin
                    // Owner ran dry: release the multiplier without a beat.
                    state_d  = IDLE;
                    rr_ptr_d = next_owner_s;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mult_tag_pipe #(
        .DEPTH (MULT_LAT + 1)
    ) u_tag_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .tag_i       (tag_in_s),
        .tag_o       (tag_out_vec_s),
        .any_valid_o (tag_any_s)
    );

    assign tag_out_s = tag_t'(tag_out_vec_s);

    // State, operand and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            mult_a_q    <= '0;
            mult_b_q    <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_p_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            mult_a_q    <= mult_a_d;
            mult_b_q    <= mult_b_d;
            res_valid_q <= tag_out_s.valid;
            res_id_q    <= ID_W'(tag_out_s.id);
            res_p_q     <= mult_p;
        end
    end

    assign req_ready = req_ready_s;
    assign mult_a    = mult_a_q;
    assign mult_b    = mult_b_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_p     = res_p_q;
    assign busy      = (state_q == BURST) | tag_any_s | res_valid_q;

endmodule

// File: tb/tb_mult_tdm_sched.sv
// Bench for mult_tdm_sched: directed and random burst traffic checked against
// a schedule-level timeline model and a behavioural 3-stage multiplier.
module tb_mult_tdm_sched;

    localparam int N    = 4;
    localparam int WA   = 8;
    localparam int WB   = 8;
    localparam int BL   = 4;
    localparam int LAT  = 3;
    localparam int PW   = WA + WB;
    localparam int IDW  = 2;
    localparam int TMAX = 128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*WA-1:0]   req_a;
    logic [N*WB-1:0]   req_b;
    logic [N-1:0]      req_ready;
    logic [WA-1:0]     mult_a;
    logic [WB-1:0]     mult_b;
    logic [PW-1:0]     mult_p;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [PW-1:0]     res_p;
    logic              busy;

    always #5 clk = ~clk;

    mult_tdm_sched #(
        .NUM_REQ   (N),
        .WIDTH_A   (WA),
        .WIDTH_B   (WB),
        .BURST_LEN (BL),
        .MULT_LAT  (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_p    (mult_p),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_p     (res_p),
        .busy      (busy)
    );

    // External signed multiplier, three register stages from ports to product.
    logic [PW-1:0] mp1, mp2, mp3;
    always_ff @(posedge clk) begin
        mp1 <= {{8{mult_a[7]}}, mult_a} * {{8{mult_b[7]}}, mult_b};
        mp2 <= mp1;
        mp3 <= mp2;
    end
    assign mult_p = mp3;

    int total = 0;
    int bad   = 0;

    logic [WA-1:0] src_a [N][16];
    logic [WB-1:0] src_b [N][16];
    int            src_len  [N];
    int            src_head [N];
    logic [N-1:0]  hs;
    int            model_ptr;

    logic           exp_rv   [TMAX];
    logic [IDW-1:0] exp_id   [TMAX];
    logic [PW-1:0]  exp_p    [TMAX];
    logic [N-1:0]   exp_rdy  [TMAX];
    logic           exp_busy [TMAX];
    int             end_s;

    task automatic chk(input string tag, input int s, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s s=%0d observed=%0h expected=%0h", tag, s, obs, exp);
        end
    endtask

    task automatic check_zero(input int s);
        chk("rst_ready", s, 32'(req_ready), 32'd0);
        chk("rst_mult_a", s, 32'(mult_a), 32'd0);
        chk("rst_mult_b", s, 32'(mult_b), 32'd0);
        chk("rst_res_valid", s, 32'(res_valid), 32'd0);
        chk("rst_res_id", s, 32'(res_id), 32'd0);
        chk("rst_res_p", s, 32'(res_p), 32'd0);
        chk("rst_busy", s, 32'(busy), 32'd0);
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_len[i]  = 0;
            src_head[i] = 0;
        end
    endtask

    task automatic fill_random(input int i, input int n);
        src_len[i] = n;
        for (int j = 0; j < n; j++) begin
            src_a[i][j] = 8'($urandom);
            src_b[i][j] = 8'($urandom);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (src_head[i] < src_len[i]) begin
                req_valid[i]        = 1'b1;
                req_a[i*WA +: WA]   = src_a[i][src_head[i]];
                req_b[i*WB +: WB]   = src_b[i][src_head[i]];
            end else begin
                req_valid[i]        = 1'b0;
                req_a[i*WA +: WA]   = 8'($urandom);
                req_b[i*WB +: WB]   = 8'($urandom);
            end
        end
    endtask

    // One clock edge; sources advance on the handshake seen just before it.
    task automatic tick();
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) src_head[i]++;
        end
        drive_inputs();
        #1;
    endtask

    // Schedule model: sample s is taken just after edge s of the phase.
    task automatic build_model();
        int mh [N];
        int t, owner, n, avail, bl_end, e, pa, pb;
        for (int s = 0; s < TMAX; s++) begin
            exp_rv[s] = 1'b0; exp_id[s] = '0; exp_p[s] = '0;
            exp_rdy[s] = '0; exp_busy[s] = 1'b0;
        end
        for (int i = 0; i < N; i++) mh[i] = src_head[i];
        t = 1;
        forever begin
            owner = -1;
            for (int k = N - 1; k >= 0; k--) begin
                if (mh[(model_ptr + k) % N] < src_len[(model_ptr + k) % N]) owner = (model_ptr + k) % N;
            end
            if (owner < 0) break;
            avail  = src_len[owner] - mh[owner];
            n      = (avail < BL) ? avail : BL;
            bl_end = (n == BL) ? t + n - 1 : t + n;
            for (int s = t; s <= bl_end; s++) begin
                exp_rdy[s]  = 4'(1 << owner);
                exp_busy[s] = 1'b1;
            end
            for (int j = 1; j <= n; j++) begin
                e  = t + j;
                pa = int'($signed(src_a[owner][mh[owner]]));
                pb = int'($signed(src_b[owner][mh[owner]]));
                exp_rv[e + LAT + 1] = 1'b1;
                exp_id[e + LAT + 1] = 2'(owner);
                exp_p[e + LAT + 1]  = 16'(pa * pb);
                for (int s = e; s <= e + LAT + 1; s++) exp_busy[s] = 1'b1;
                mh[owner]++;
            end
            model_ptr = (owner + 1) % N;
            t = bl_end + 2;
        end
        end_s = t + LAT + 2;
    endtask

    // Run a phase to drain; rst_at > 0 pulses reset so it is sampled at that edge.
    task automatic run_phase(input int rst_at);
        build_model();
        drive_inputs();
        for (int s = 1; s <= end_s; s++) begin
            if (s == rst_at) rst_n = 1'b0;
            tick();
            if (s == rst_at) begin
                rst_n = 1'b1;
                check_zero(s);
                for (int i = 0; i < N; i++) src_head[i] = src_len[i];
                drive_inputs();
                model_ptr = 0;
                return;
            end
            chk("res_valid", s, 32'(res_valid), 32'(exp_rv[s]));
            if (exp_rv[s]) begin
                chk("res_id", s, 32'(res_id), 32'(exp_id[s]));
                chk("res_p", s, 32'(res_p), 32'(exp_p[s]));
            end
            chk("req_ready", s, 32'(req_ready), 32'(exp_rdy[s]));
            chk("busy", s, 32'(busy), 32'(exp_busy[s]));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        model_ptr = 0;
        clear_src();
        repeat (3) tick();
        check_zero(0);
        rst_n = 1'b1;

        // Round-robin: everyone busy, five beats each.
        clear_src();
        for (int i = 0; i < N; i++) fill_random(i, 5);
        run_phase(0);

        // Single beat from requester 2: 3 * -5.
        clear_src();
        src_len[2] = 1; src_a[2][0] = 8'd3; src_b[2][0] = 8'hFB;
        run_phase(0);

        // Signed extremes on requester 0.
        clear_src();
        src_len[0] = 3;
        src_a[0][0] = 8'h80; src_b[0][0] = 8'h80;
        src_a[0][1] = 8'h80; src_b[0][1] = 8'h7F;
        src_a[0][2] = 8'h7F; src_b[0][2] = 8'h7F;
        run_phase(0);

        // Early release: requester 1 has only two beats, requester 2 waits.
        clear_src();
        fill_random(1, 2);
        fill_random(2, 3);
        run_phase(0);

        // Random traffic mixes.
        for (int p = 0; p < 6; p++) begin
            clear_src();
            for (int i = 0; i < N; i++) fill_random(i, int'($urandom_range(6, 0)));
            run_phase(0);
        end

        // Reset two cycles after requester 2's beat is accepted.
        clear_src();
        fill_random(2, 1);
        run_phase(4);

        // Pointer must be back at 0: requester 1 beats requester 3.
        clear_src();
        fill_random(1, 1);
        fill_random(3, 1);
        run_phase(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
